// File: rtl/weight_stream_unpacker.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | weight_stream_unpacker                                                    |
// | Buffers a packed kernel word and replays it one element per cycle; also  |
// | latches bias words. Optional macro WSU_REPLAY_EN adds a replay input.     |
// | Revision: 1.0                                                             |
// +--------------------------------------------------------------------------+
module weight_stream_unpacker #(
  parameter int DATA_WIDTH  = 8,
  parameter int NUM_WEIGHTS = 9,
  parameter int BIAS_WIDTH  = 16,
  parameter int IDX_WIDTH   = 4
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              load_valid,
  output logic                              load_ready,
  input  logic                              sel_bias,
`ifdef WSU_REPLAY_EN
  input  logic                              replay,
`endif
  input  logic [NUM_WEIGHTS*DATA_WIDTH-1:0] load_data,
  output logic                              w_valid,
  input  logic                              w_ready,
  output logic [DATA_WIDTH-1:0]             w_data,
  output logic [IDX_WIDTH-1:0]              w_index,
  output logic                              w_last,
  output logic [BIAS_WIDTH-1:0]             bias_out,
  output logic                              bias_valid,
  output logic [7:0]                        sets_done
);

  localparam logic [IDX_WIDTH-1:0] LAST_IDX = IDX_WIDTH'(NUM_WEIGHTS - 1);

  typedef enum logic [0:0] {
    ST_IDLE   = 1'b0,
    ST_STREAM = 1'b1
  } state_t;

  state_t                  state_q, state_d;
  logic [DATA_WIDTH-1:0]   buf_q [NUM_WEIGHTS];
  logic [DATA_WIDTH-1:0]   buf_d [NUM_WEIGHTS];
  logic [DATA_WIDTH-1:0]   load_elem [NUM_WEIGHTS];
  logic [IDX_WIDTH-1:0]    idx_q, idx_d;
  logic [BIAS_WIDTH-1:0]   bias_q, bias_d;
  logic                    bias_valid_q, bias_valid_d;
  logic [7:0]              sets_q, sets_d;
  logic                    replay_req;
  logic                    weight_load;

  generate
    for (genvar k = 0; k < NUM_WEIGHTS; k++) begin : g_unpack
      assign load_elem[k] = load_data[k*DATA_WIDTH +: DATA_WIDTH];
    end
  endgenerate

`ifdef WSU_REPLAY_EN
  // Replay is only honoured once a real weight set has been captured.
  logic loaded_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      loaded_q <= 1'b0;
    end else if (weight_load) begin
      loaded_q <= 1'b1;
    end
  end

  assign replay_req = replay & loaded_q;
`else
  assign replay_req = 1'b0;
`endif

  assign weight_load = (state_q == ST_IDLE) && load_valid && !sel_bias;

  always_comb begin
    state_d      = state_q;
    buf_d        = buf_q;
    idx_d        = idx_q;
    bias_d       = bias_q;
    bias_valid_d = bias_valid_q;
    sets_d       = sets_q;
    case (state_q)
      ST_IDLE: begin
        // A real load always takes priority over a replay request.
        if (load_valid) begin
          if (sel_bias) begin
            bias_d       = load_data[BIAS_WIDTH-1:0];
            bias_valid_d = 1'b1;
          end else begin
            buf_d   = load_elem;
            idx_d   = '0;
            state_d = ST_STREAM;
          end
        end else if (replay_req) begin
          idx_d   = '0;
          state_d = ST_STREAM;
        end
      end
      ST_STREAM: begin
        if (w_ready) begin
          if (idx_q == LAST_IDX) begin
            idx_d   = '0;
            sets_d  = sets_q + 8'd1;
            state_d = ST_IDLE;
          end else begin
            idx_d = idx_q + IDX_WIDTH'(1);
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    w_data = '0;
    for (int k = 0; k < NUM_WEIGHTS; k++) begin
      if ((state_q == ST_STREAM) && (idx_q == IDX_WIDTH'(k))) begin
        w_data = buf_q[k];
      end
    end
  end

  assign load_ready = (state_q == ST_IDLE);
  assign w_valid    = (state_q == ST_STREAM);
  assign w_index    = idx_q;
  assign w_last     = (state_q == ST_STREAM) && (idx_q == LAST_IDX);
  assign bias_out   = bias_q;
  assign bias_valid = bias_valid_q;
  assign sets_done  = sets_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      idx_q        <= '0;
      bias_q       <= '0;
      bias_valid_q <= 1'b0;
      sets_q       <= '0;
      for (int k = 0; k < NUM_WEIGHTS; k++) begin
        buf_q[k] <= '0;
      end
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      bias_q       <= bias_d;
      bias_valid_q <= bias_valid_d;
      sets_q       <= sets_d;
      buf_q        <= buf_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_weight_stream_unpacker.sv
`default_nettype none
`timescale 1ns/1ps
// +--------------------------------------------------------------------------+
// | tb_weight_stream_unpacker                                                 |
// | Randomised self-checking bench for weight_stream_unpacker.                |
// | Revision: 1.0                                                             |
// +--------------------------------------------------------------------------+
module tb_weight_stream_unpacker;

  localparam int DW = 8;
  localparam int NW = 9;
  localparam int BW = 16;
  localparam int IW = 4;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             load_valid;
  logic             load_ready;
  logic             sel_bias;
  logic             replay;
  logic [NW*DW-1:0] load_data;
  logic             w_valid;
  logic             w_ready;
  logic [DW-1:0]    w_data;
  logic [IW-1:0]    w_index;
  logic             w_last;
  logic [BW-1:0]    bias_out;
  logic             bias_valid;
  logic [7:0]       sets_done;

  int               pass_cnt = 0;
  int               total_cnt = 0;
  int               exp_sets = 0;
  logic [NW*DW-1:0] seq_word;

  always #5 clk = ~clk;

  weight_stream_unpacker #(
    .DATA_WIDTH (DW),
    .NUM_WEIGHTS(NW),
    .BIAS_WIDTH (BW),
    .IDX_WIDTH  (IW)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .load_valid(load_valid),
    .load_ready(load_ready),
    .sel_bias  (sel_bias),
`ifdef WSU_REPLAY_EN
    .replay    (replay),
`endif
    .load_data (load_data),
    .w_valid   (w_valid),
    .w_ready   (w_ready),
    .w_data    (w_data),
    .w_index   (w_index),
    .w_last    (w_last),
    .bias_out  (bias_out),
    .bias_valid(bias_valid),
    .sets_done (sets_done)
  );

  function automatic logic [DW-1:0] elem_of(input logic [NW*DW-1:0] word, input int k);
    return DW'(word >> (k * DW));
  endfunction

  function automatic logic [NW*DW-1:0] rand_word();
    logic [NW*DW-1:0] w = '0;
    for (int k = 0; k < NW; k++) w = (w << DW) | (NW*DW)'($urandom_range(0, 255));
    return w;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present a weight word and wait for its acceptance edge.
  task automatic load_word(input logic [NW*DW-1:0] word, input bit keep_valid);
    int cyc = 0;
    sel_bias   = 1'b0;
    load_data  = word;
    load_valid = 1'b1;
    while (!load_ready && cyc < 200) begin
      step();
      cyc++;
    end
    total_cnt++;
    if (cyc >= 200) $display("FAIL load_accept_timeout: load_ready=%0b required 1", load_ready);
    else pass_cnt++;
    step();
    if (!keep_valid) load_valid = 1'b0;
    total_cnt++;
    if (w_valid !== 1'b1) $display("FAIL w_valid_latency: got %0b required 1", w_valid);
    else pass_cnt++;
  endtask

  // mode 0: always ready, 1: random ready, 2: ready pattern 1,0,0 repeating.
  task automatic drain(input logic [NW*DW-1:0] word, input int mode);
    int   k = 0;
    int   cyc = 0;
    logic rdy;
    while (k < NW && cyc < 300) begin
      total_cnt++;
      if (w_valid !== 1'b1 || w_data !== elem_of(word, k) || w_index !== IW'(k) ||
          w_last !== (k == NW-1) || load_ready !== 1'b0)
        $display("FAIL stream_elem%0d: valid=%0b data=%h idx=%0d last=%0b lrdy=%0b required 1 %h %0d %0b 0",
                 k, w_valid, w_data, w_index, w_last, load_ready, elem_of(word, k), k, (k == NW-1));
      else pass_cnt++;
      case (mode)
        0:       rdy = 1'b1;
        1:       rdy = 1'($urandom_range(0, 1));
        default: rdy = (cyc % 3 == 0);
      endcase
      w_ready = rdy;
      step();
      if (rdy) k++;
      cyc++;
    end
    w_ready = 1'b0;
    exp_sets = (exp_sets + 1) % 256;
    total_cnt++;
    if (k != NW) $display("FAIL drain_timeout: streamed %0d required %0d", k, NW);
    else pass_cnt++;
    total_cnt++;
    if (sets_done !== 8'(exp_sets) || load_ready !== 1'b1 || w_valid !== 1'b0 || w_last !== 1'b0)
      $display("FAIL set_complete: sets=%0d lrdy=%0b valid=%0b last=%0b required %0d 1 0 0",
               sets_done, load_ready, w_valid, w_last, exp_sets);
    else pass_cnt++;
  endtask

  task automatic check_reset_outputs(input string tag);
    total_cnt++;
    if (load_ready !== 1'b1 || w_valid !== 1'b0 || w_index !== '0 || w_last !== 1'b0 ||
        w_data !== '0 || bias_out !== '0 || bias_valid !== 1'b0 || sets_done !== '0)
      $display("FAIL %s: lrdy=%0b valid=%0b idx=%0d last=%0b data=%h bias=%h bv=%0b sets=%0d required 1 0 0 0 00 0000 0 0",
               tag, load_ready, w_valid, w_index, w_last, w_data, bias_out, bias_valid, sets_done);
    else pass_cnt++;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; load_valid = 1'b0; sel_bias = 1'b0; replay = 1'b0;
    w_ready = 1'b0; load_data = '0;
    step(); step();
    check_reset_outputs("reset_state");
    rst_n = 1'b1;
    exp_sets = 0;
    step();
    check_reset_outputs("after_reset_idle");
  endtask

  task automatic test_stream_basic();
    load_word(seq_word, 1'b0);
    drain(seq_word, 0);
  endtask

  task automatic test_stall();
    logic [NW*DW-1:0] w;
    load_word(seq_word, 1'b0);
    drain(seq_word, 2);
    for (int r = 0; r < 4; r++) begin
      w = rand_word();
      load_word(w, 1'b0);
      drain(w, 1);
    end
  endtask

  task automatic test_bias();
    logic [NW*DW-1:0] w;
    for (int r = 0; r < 2; r++) begin
      w = rand_word();
      if (r == 0) w[BW-1:0] = 16'hBEEF;
      sel_bias = 1'b1; load_data = w; load_valid = 1'b1;
      step();
      load_valid = 1'b0; sel_bias = 1'b0;
      total_cnt++;
      if (bias_out !== BW'(w) || bias_valid !== 1'b1)
        $display("FAIL bias_load%0d: bias=%h bv=%0b required %h 1", r, bias_out, bias_valid, BW'(w));
      else pass_cnt++;
      total_cnt++;
      if (w_valid !== 1'b0 || load_ready !== 1'b1 || sets_done !== 8'(exp_sets))
        $display("FAIL bias_stays_idle%0d: valid=%0b lrdy=%0b sets=%0d required 0 1 %0d",
                 r, w_valid, load_ready, sets_done, exp_sets);
      else pass_cnt++;
    end
  endtask

  task automatic test_load_blocked();
    logic [NW*DW-1:0] a, b;
    a = rand_word();
    b = {NW{8'hFF}};
    b[DW-1:0] = 8'(a[DW-1:0] + 8'd1);
    load_word(a, 1'b1);
    load_data = b;
    drain(a, 1);
    step();
    load_valid = 1'b0;
    total_cnt++;
    if (w_valid !== 1'b1) $display("FAIL blocked_then_accept: valid=%0b required 1", w_valid);
    else pass_cnt++;
    drain(b, 0);
  endtask

  task automatic test_midstream_reset();
    logic [NW*DW-1:0] w;
    w = rand_word();
    load_word(w, 1'b0);
    w_ready = 1'b1;
    repeat (4) step();
    total_cnt++;
    if (w_index !== IW'(4) || w_data !== elem_of(w, 4))
      $display("FAIL midstream_pos: idx=%0d data=%h required 4 %h", w_index, w_data, elem_of(w, 4));
    else pass_cnt++;
    rst_n = 1'b0;
    step();
    check_reset_outputs("midstream_reset");
    rst_n = 1'b1; w_ready = 1'b0;
    exp_sets = 0;
    step();
    check_reset_outputs("midstream_reset_idle");
  endtask

`ifdef WSU_REPLAY_EN
  task automatic test_replay();
    logic [NW*DW-1:0] w;
    load_word(seq_word, 1'b0);
    drain(seq_word, 0);
    replay = 1'b1;
    step();
    replay = 1'b0;
    drain(seq_word, 1);
    rst_n = 1'b0; step(); rst_n = 1'b1; step();
    exp_sets = 0;
    replay = 1'b1;
    for (int c = 0; c < 3; c++) begin
      step();
      total_cnt++;
      if (w_valid !== 1'b0) $display("FAIL replay_unloaded%0d: valid=%0b required 0", c, w_valid);
      else pass_cnt++;
    end
    w = rand_word();
    load_word(w, 1'b0);
    replay = 1'b0;
    drain(w, 0);
  endtask
`endif

  initial begin
    for (int k = 0; k < NW; k++) seq_word[k*DW +: DW] = 8'(k + 1);
    test_reset();
    test_stream_basic();
    test_stall();
    test_bias();
    test_load_blocked();
    test_midstream_reset();
`ifdef WSU_REPLAY_EN
    test_replay();
`endif
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
`default_nettype wire
